adc_sample_sequencer: RTL and testbench

- Drives the conversion strobe (`latch`) of the MCP3201 ADC front-end at a fixed sample rate.
- Captures the 12-bit `value` that front-end returns once each conversion completes.
- Block-averages 2^LOG2_N consecutive samples and presents a decimated result with a one-cycle valid strobe.
- Sits between the ADC interface and the motion-control datapath: it feeds the ADC's `latch` input and consumes the ADC's `value` output.

---
 rtl/adc_sample_sequencer_if.sv | 37 +++
 rtl/adc_sample_sequencer.sv | 175 +++++++++++++++++
 tb/tb_adc_sample_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_sequencer_if.sv
// adc_sample_sequencer_if
// Groups the sequencer's control, ADC-side and result signals.
//   enable        : run/stop request (1 = sequencing active)
//   latch         : conversion start strobe to the ADC front-end
//   value[11:0]   : conversion result from the ADC front-end
//   raw_sample    : last captured single sample
//   sample_valid  : one-cycle pulse when raw_sample updates
//   avg           : block average of the last 2^LOG2_N samples
//   avg_valid     : one-cycle pulse when avg updates
//   overrun       : sticky, a period tick arrived while a conversion was busy
//   fsm_state     : debug view of the sequencer state (IDLE=0, TRIG=1, WAIT=2, CAPTURE=3)
// Handshake: there is no back-pressure. sample_valid and avg_valid are
// single-cycle strobes; the matching data is stable in the same cycle and
// holds until the next strobe. enable is a level, sampled on every rising edge.
interface adc_sample_sequencer_if;
  logic        enable;
  logic        latch;
  logic [11:0] value;
  logic [11:0] raw_sample;
  logic        sample_valid;
  logic [11:0] avg;
  logic        avg_valid;
  logic        overrun;
  logic [1:0]  fsm_state;

  // master: the environment (controller + ADC front-end)
  modport master (
    output enable, value,
    input  latch, raw_sample, sample_valid, avg, avg_valid, overrun, fsm_state
  );

  // slave: the sequencer itself
  modport slave (
    input  enable, value,
    output latch, raw_sample, sample_valid, avg, avg_valid, overrun, fsm_state
  );
endinterface

// File: rtl/adc_sample_sequencer.sv
// adc_sample_sequencer
// Strobes the MCP3201 front-end latch once every CLK_DIV cycles, captures the
// 12-bit result CONV_CYCLES after latch falls, and block-averages 2^LOG2_N
// samples into a decimated result.
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : adc_sample_sequencer_if.slave (enable, latch, value, raw_sample,
//            sample_valid, avg, avg_valid, overrun, fsm_state)
// Timing, counting the edge where latch rises as edge 0:
//   latch high after edges 0 .. LATCH_LEN-1, low from edge LATCH_LEN
//   capture (sample_valid) at edge LATCH_LEN + CONV_CYCLES
//   avg_valid one edge after the sample_valid of every 2^LOG2_N-th sample
// CONV_CYCLES must be >= 2 and LATCH_LEN >= 1.
module adc_sample_sequencer #(
  parameter int CLK_DIV     = 5000,
  parameter int LATCH_LEN   = 25,
  parameter int CONV_CYCLES = 800,
  parameter int LOG2_N      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  adc_sample_sequencer_if.slave  bus
);

  localparam int PC_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SC_MAX = (LATCH_LEN > CONV_CYCLES) ? LATCH_LEN : CONV_CYCLES;
  localparam int SC_W   = $clog2(SC_MAX + 1);
  localparam int ACC_W  = 12 + LOG2_N;

  typedef enum logic [1:0] {IDLE = 2'd0, TRIG = 2'd1, WAIT = 2'd2, CAPTURE = 2'd3} state_t;

  state_t            state, state_d;
  logic [SC_W-1:0]   sc, sc_d;
  logic              latch_q, latch_d;
  logic              do_capture;
  logic              tick;
  logic [PC_W-1:0]   pc;
  logic [ACC_W-1:0]  acc;
  logic [LOG2_N-1:0] cnt;
  logic              avg_pending;
  logic [11:0]       raw_q;
  logic [11:0]       avg_q;
  logic              sample_valid_q;
  logic              avg_valid_q;
  logic              overrun_q;

  // Period tick: count 0 of the enabled period counter. The counter sits at 0
  // while disabled, so the first enabled edge is a tick.
  assign tick = bus.enable && (pc == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= '0;
    end else if (!bus.enable) begin
      pc <= '0;
    end else if (pc == PC_W'(CLK_DIV - 1)) begin
      pc <= '0;
    end else begin
      pc <= pc + PC_W'(1);
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sc      <= '0;
      latch_q <= 1'b0;
    end else begin
      state   <= state_d;
      sc      <= sc_d;
      latch_q <= latch_d;
    end
  end

  // FSM next state. WAIT leaves one cycle early so that the CAPTURE cycle
  // completes exactly CONV_CYCLES edges after latch falls.
  always_comb begin
    state_d    = state;
    sc_d       = sc + SC_W'(1);
    latch_d    = latch_q;
    do_capture = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
      sc_d    = '0;
      latch_d = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sc_d = '0;
          if (tick) begin
            state_d = TRIG;
            latch_d = 1'b1;
          end
        end
        TRIG: begin
          if (sc == SC_W'(LATCH_LEN - 1)) begin
            state_d = WAIT;
            sc_d    = '0;
            latch_d = 1'b0;
          end
        end
        WAIT: begin
          if (sc == SC_W'(CONV_CYCLES - 2)) begin
            state_d = CAPTURE;
            sc_d    = '0;
          end
        end
        CAPTURE: begin
          do_capture = 1'b1;
          state_d    = IDLE;
          sc_d       = '0;
        end
        default: begin
          state_d = IDLE;
          sc_d    = '0;
          latch_d = 1'b0;
        end
      endcase
    end
  end

  // Sample capture, accumulation and decimation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_q          <= '0;
      avg_q          <= '0;
      sample_valid_q <= 1'b0;
      avg_valid_q    <= 1'b0;
      overrun_q      <= 1'b0;
      acc            <= '0;
      cnt            <= '0;
      avg_pending    <= 1'b0;
    end else if (!bus.enable) begin
      // Abort: drop any conversion or average in flight, keep published data.
      sample_valid_q <= 1'b0;
      avg_valid_q    <= 1'b0;
      overrun_q      <= 1'b0;
      acc            <= '0;
      cnt            <= '0;
      avg_pending    <= 1'b0;
    end else begin
      sample_valid_q <= do_capture;
      avg_valid_q    <= avg_pending;
      avg_pending    <= 1'b0;
      if (tick && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end
      if (do_capture) begin
        raw_q <= bus.value;
        acc   <= acc + {{LOG2_N{1'b0}}, bus.value};
        cnt   <= cnt + LOG2_N'(1);
        // cnt at all-ones means this is the last sample of the block
        if (cnt == '1) begin
          avg_pending <= 1'b1;
        end
      end
      // acc already holds the last sample of the block here
      if (avg_pending) begin
        avg_q <= acc[ACC_W-1:LOG2_N];
        acc   <= '0;
      end
    end
  end

  assign bus.latch        = latch_q;
  assign bus.raw_sample   = raw_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.avg          = avg_q;
  assign bus.avg_valid    = avg_valid_q;
  assign bus.overrun      = overrun_q;
  assign bus.fsm_state    = state;

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// tb_adc_sample_sequencer
// Two sequencers share clock, reset, enable and value: dut0 with a legal
// CLK_DIV=100 and dut1 with CLK_DIV=20, which is shorter than one conversion.
// A timeline model derives, for each instance, when conversions start and
// complete from the period/latch/conversion lengths and keeps the running
// block of samples; every cycle all outputs are compared against it.
module tb_adc_sample_sequencer;

  localparam int LATCH_LEN   = 2;
  localparam int CONV_CYCLES = 20;
  localparam int LOG2_N      = 2;
  localparam int N           = 1 << LOG2_N;
  localparam int CD0         = 100;
  localparam int CD1         = 20;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] value = 12'h000;

  always #5 clk = ~clk;

  adc_sample_sequencer_if bus0 ();
  adc_sample_sequencer_if bus1 ();

  assign bus0.enable = enable;
  assign bus0.value  = value;
  assign bus1.enable = enable;
  assign bus1.value  = value;

  adc_sample_sequencer #(.CLK_DIV(CD0), .LATCH_LEN(LATCH_LEN), .CONV_CYCLES(CONV_CYCLES), .LOG2_N(LOG2_N))
    dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  adc_sample_sequencer #(.CLK_DIV(CD1), .LATCH_LEN(LATCH_LEN), .CONV_CYCLES(CONV_CYCLES), .LOG2_N(LOG2_N))
    dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model: per-instance timeline state
  int          m_e[2];        // rising edges since reset
  int          m_pc[2];       // position within the sample period
  int          m_start[2];    // edge at which the live conversion latched, -1 if none
  int          m_cap[2];      // edge at which the live conversion completes
  int          m_avg_due[2];  // edge at which the pending average is published
  int          m_sum[2];
  int          m_n[2];
  logic [11:0] m_pend[2];
  bit          x_latch[2], x_sv[2], x_av[2], x_ovr[2];
  logic [11:0] x_raw[2], x_avg[2];

  task automatic model_reset(input int i);
    m_e[i] = 0; m_pc[i] = 0; m_start[i] = -1; m_cap[i] = -1; m_avg_due[i] = -1;
    m_sum[i] = 0; m_n[i] = 0; m_pend[i] = '0;
    x_latch[i] = 0; x_sv[i] = 0; x_av[i] = 0; x_ovr[i] = 0;
    x_raw[i] = '0; x_avg[i] = '0;
  endtask

  task automatic model_step(input int i, input bit en, input logic [11:0] val);
    int  cd;
    bit  tick;
    cd = (i == 0) ? CD0 : CD1;
    if (!en) begin
      m_pc[i] = 0; m_start[i] = -1; m_cap[i] = -1; m_avg_due[i] = -1;
      m_sum[i] = 0; m_n[i] = 0;
      x_latch[i] = 0; x_sv[i] = 0; x_av[i] = 0; x_ovr[i] = 0;
    end else begin
      tick = (m_pc[i] == 0);
      m_pc[i] = (m_pc[i] + 1) % cd;
      if (tick) begin
        if (m_start[i] >= 0) x_ovr[i] = 1;
        else begin
          m_start[i] = m_e[i];
          m_cap[i]   = m_e[i] + LATCH_LEN + CONV_CYCLES;
        end
      end
      x_latch[i] = (m_start[i] >= 0) && (m_e[i] < m_start[i] + LATCH_LEN);
      x_sv[i] = (m_e[i] == m_cap[i]);
      x_av[i] = (m_e[i] == m_avg_due[i]);
      if (x_av[i]) begin
        x_avg[i] = m_pend[i];
        if (i == 0) exp_q.push_back(m_pend[i]);
      end
      if (x_sv[i]) begin
        x_raw[i] = val;
        m_sum[i] += int'(val);
        m_n[i]++;
        if (m_n[i] == N) begin
          m_pend[i]    = 12'(m_sum[i] / N);
          m_avg_due[i] = m_e[i] + 1;
          m_sum[i] = 0;
          m_n[i]   = 0;
        end
        m_start[i] = -1;
        m_cap[i]   = -1;
      end
    end
    m_e[i]++;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset(0);
    else model_step(0, enable, value);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset(1);
    else model_step(1, enable, value);
  end

  // per-cycle comparison against the model
  always @(negedge clk) begin
    check("latch0", bus0.latch, x_latch[0]);
    check("sv0", bus0.sample_valid, x_sv[0]);
    check("raw0", bus0.raw_sample, x_raw[0]);
    check("av0", bus0.avg_valid, x_av[0]);
    check("avg0", bus0.avg, x_avg[0]);
    check("ovr0", bus0.overrun, x_ovr[0]);
    check("latch1", bus1.latch, x_latch[1]);
    check("sv1", bus1.sample_valid, x_sv[1]);
    check("raw1", bus1.raw_sample, x_raw[1]);
    check("av1", bus1.avg_valid, x_av[1]);
    check("avg1", bus1.avg, x_avg[1]);
    check("ovr1", bus1.overrun, x_ovr[1]);
    if (bus0.avg_valid) begin
      if (exp_q.size() == 0) check("avg_q_empty", 1, 0);
      else check("avg_q", bus0.avg, exp_q.pop_front());
    end
  end

  // driver tasks
  task automatic wait_sv0(input int limit);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus0.sample_valid && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) check("sv_timeout", 1, 0);
  endtask

  task automatic wait_av0(input int limit);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus0.avg_valid && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) check("av_timeout", 1, 0);
  endtask

  task automatic wait_latch0(input logic lvl, input int limit);
    int k;
    k = 0;
    @(negedge clk);
    while (bus0.latch !== lvl && k < limit) begin
      @(negedge clk);
      k++;
    end
    if (k >= limit) check("latch_timeout", 1, 0);
  endtask

  initial begin
    int sv_seen;
    // reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_latch", bus0.latch, 0);
    check("rst_raw", bus0.raw_sample, 0);
    check("rst_avg", bus0.avg, 0);
    check("rst_ovr", bus0.overrun, 0);

    // constant value block
    value  = 12'h123;
    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    check("first_latch", bus0.latch, 1);
    for (int s = 0; s < N; s++) begin
      wait_sv0(150);
      check("raw_123", bus0.raw_sample, 12'h123);
    end
    wait_av0(3);
    check("avg_123", bus0.avg, 12'h123);

    // truncating average
    value = 12'hFFF;
    for (int s = 0; s < N; s++) begin
      wait_sv0(150);
      if (s == N - 2) value = 12'h001;
    end
    wait_av0(3);
    check("avg_trunc", bus0.avg, 12'hBFF);
    check("ovr_sticky1", bus1.overrun, 1);
    check("ovr_clean0", bus0.overrun, 0);

    // abort mid-conversion, then restart a fresh block
    wait_latch0(1'b1, 150);
    repeat (4) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_latch", bus0.latch, 0);
    sv_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus0.sample_valid) sv_seen++;
    end
    check("abort_no_sv", sv_seen, 0);
    value  = 12'h0AB;
    enable = 1'b1;
    @(negedge clk);
    check("reenable_latch", bus0.latch, 1);
    for (int s = 0; s < N; s++) wait_sv0(150);
    wait_av0(3);
    check("avg_fresh", bus0.avg, 12'h0AB);

    // randomized run with occasional enable drops
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      value = 12'($urandom_range(0, 4095));
      if (enable && $urandom_range(0, 399) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 9) == 0) enable = 1'b1;
    end
    enable = 1'b1;

    // asynchronous reset during WAIT
    wait_latch0(1'b1, 150);
    wait_latch0(1'b0, 10);
    repeat (5) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("arst_latch", bus0.latch, 0);
    check("arst_sv", bus0.sample_valid, 0);
    check("arst_raw", bus0.raw_sample, 0);
    check("arst_avg", bus0.avg, 0);
    check("arst_av", bus0.avg_valid, 0);
    check("arst_ovr", bus1.overrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_latch", bus0.latch, 1);
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      value = 12'($urandom_range(0, 4095));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
